// File: rtl/j_pulse_pkg.sv
// Shared types and encodings for the multi-channel compare pulse generator.
package j_pulse_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_JK    = 2'd1,
        MODE_TOG   = 2'd2,
        MODE_JKINV = 2'd3
    } mode_t;

    localparam logic [1:0] SEL_START  = 2'd0;
    localparam logic [1:0] SEL_STOP   = 2'd1;
    localparam logic [1:0] SEL_PERIOD = 2'd2;
    localparam logic [1:0] SEL_MODE   = 2'd3;

    // J = start hit, K = stop hit; both together toggle.
    function automatic logic jk_next(input logic q, input logic j, input logic k);
        case ({j, k})
            2'b10:   return 1'b1;
            2'b01:   return 1'b0;
            2'b11:   return ~q;
            default: return q;
        endcase
    endfunction

endpackage

// File: rtl/j_pulse_gen_chan.sv
// One output channel: double-buffered start/stop/mode compares and the JK/toggle state.
module j_pulse_gen_chan
    import j_pulse_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         sys_clk,
    input  logic         reset,
    input  logic [W-1:0] count,
    input  logic         tick_act,
    input  logic         load,
    input  logic         wr_en,
    input  logic [1:0]   wr_sel,
    input  logic [W-1:0] wr_data,
    output logic         pulse
);

    logic [W-1:0] start_sh_q, start_sh_d, start_act_q, start_act_d;
    logic [W-1:0] stop_sh_q, stop_sh_d, stop_act_q, stop_act_d;
    mode_t        mode_sh_q, mode_sh_d, mode_act_q, mode_act_d;
    logic         st_q, st_d, pulse_q, pulse_d;
    logic         start_hit, stop_hit;

    assign start_hit = (count == start_act_q);
    assign stop_hit  = (count == stop_act_q);
    assign pulse     = pulse_q;

    always_comb begin
        start_sh_d  = start_sh_q;
        stop_sh_d   = stop_sh_q;
        mode_sh_d   = mode_sh_q;
        start_act_d = start_act_q;
        stop_act_d  = stop_act_q;
        mode_act_d  = mode_act_q;
        st_d        = st_q;
        pulse_d     = pulse_q;

        // The tick is evaluated with the active values from before any reload.
        if (tick_act) begin
            case (mode_act_q)
                MODE_JK: begin
                    st_d    = jk_next(st_q, start_hit, stop_hit);
                    pulse_d = st_d;
                end
                MODE_TOG: begin
                    st_d    = st_q ^ start_hit;
                    pulse_d = st_d;
                end
                MODE_JKINV: begin
                    st_d    = jk_next(st_q, start_hit, stop_hit);
                    pulse_d = ~st_d;
                end
                default: begin
                    st_d    = 1'b0;
                    pulse_d = 1'b0;
                end
            endcase
        end

        if (load) begin
            start_act_d = start_sh_q;
            stop_act_d  = stop_sh_q;
            mode_act_d  = mode_sh_q;
            if (mode_sh_q == MODE_JKINV && mode_act_q != MODE_JKINV)
                st_d = 1'b0;
        end

        if (wr_en) begin
            case (wr_sel)
                SEL_START: start_sh_d = wr_data;
                SEL_STOP:  stop_sh_d  = wr_data;
                SEL_MODE:  mode_sh_d  = mode_t'(wr_data[1:0]);
                default:   ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            start_sh_q  <= '0;
            stop_sh_q   <= '0;
            mode_sh_q   <= MODE_OFF;
            start_act_q <= '0;
            stop_act_q  <= '0;
            mode_act_q  <= MODE_OFF;
            st_q        <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            start_sh_q  <= start_sh_d;
            stop_sh_q   <= stop_sh_d;
            mode_sh_q   <= mode_sh_d;
            start_act_q <= start_act_d;
            stop_act_q  <= stop_act_d;
            mode_act_q  <= mode_act_d;
            st_q        <= st_d;
            pulse_q     <= pulse_d;
        end
    end

endmodule

// File: rtl/j_pulse_gen.sv
// Tick-driven shared counter with a double-buffered period, driving N compare pulse channels.
module j_pulse_gen
    import j_pulse_pkg::*;
#(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          enable,
    input  logic          wr,
    input  logic [CW-1:0] wr_chan,
    input  logic [1:0]    wr_sel,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  count,
    output logic          wrap,
    output logic [N-1:0]  pulse
);

    logic [W-1:0] count_q, count_d;
    logic [W-1:0] period_sh_q, period_sh_d, period_act_q, period_act_d;
    logic         wrap_q, wrap_d;
    logic         tick_act, load;

    assign tick_act = tick & enable;
    assign load     = tick_act & (count_q == period_act_q);
    assign count    = count_q;
    assign wrap     = wrap_q;

    always_comb begin
        count_d      = count_q;
        wrap_d       = 1'b0;
        period_sh_d  = period_sh_q;
        period_act_d = period_act_q;

        if (load) begin
            count_d      = '0;
            wrap_d       = 1'b1;
            period_act_d = period_sh_q;
        end else if (tick_act) begin
            count_d = count_q + 1'b1;
        end

        if (wr && wr_sel == SEL_PERIOD)
            period_sh_d = wr_data;
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            wrap_q       <= 1'b0;
            period_sh_q  <= '1;
            period_act_q <= '1;
        end else begin
            count_q      <= count_d;
            wrap_q       <= wrap_d;
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
        end
    end

    // Channel indices at or above N never match, so such writes are dropped.
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        logic chan_wr;
        assign chan_wr = wr && (wr_sel != SEL_PERIOD) && (wr_chan == CW'(gi));

        j_pulse_gen_chan #(.W(W)) u_chan (
            .sys_clk  (sys_clk),
            .reset    (reset),
            .count    (count_q),
            .tick_act (tick_act),
            .load     (load),
            .wr_en    (chan_wr),
            .wr_sel   (wr_sel),
            .wr_data  (wr_data),
            .pulse    (pulse[gi])
        );
    end

endmodule

// File: tb/tb_j_pulse_gen.sv
// Scoreboard bench for j_pulse_gen: a cycle model predicts count/wrap/pulse for every sys_clk.
module tb_j_pulse_gen;

    localparam int W  = 8;
    localparam int N  = 5;
    localparam int CW = 3;

    logic          sys_clk = 1'b0;
    logic          reset   = 1'b1;
    logic          tick    = 1'b0;
    logic          enable  = 1'b0;
    logic          wr      = 1'b0;
    logic [CW-1:0] wr_chan = '0;
    logic [1:0]    wr_sel  = '0;
    logic [W-1:0]  wr_data = '0;
    logic [W-1:0]  count;
    logic          wrap;
    logic [N-1:0]  pulse;

    j_pulse_gen #(.W(W), .N(N)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .tick    (tick),
        .enable  (enable),
        .wr      (wr),
        .wr_chan (wr_chan),
        .wr_sel  (wr_sel),
        .wr_data (wr_data),
        .count   (count),
        .wrap    (wrap),
        .pulse   (pulse)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [W-1:0] c;
        logic         w;
        logic [N-1:0] p;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference state
    int           m_count, m_period_sh, m_period_act;
    logic         m_wrap;
    logic [N-1:0] m_pulse, m_st;
    int           m_start_sh[N], m_start_act[N], m_stop_sh[N], m_stop_act[N];
    int           m_mode_sh[N], m_mode_act[N];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_wrap = 1'b0; m_pulse = '0; m_st = '0;
        m_period_sh = 255; m_period_act = 255;
        for (int c = 0; c < N; c++) begin
            m_start_sh[c] = 0; m_start_act[c] = 0;
            m_stop_sh[c]  = 0; m_stop_act[c]  = 0;
            m_mode_sh[c]  = 0; m_mode_act[c]  = 0;
        end
    endtask

    // Advance the model by one sys_clk using the inputs currently driven.
    task automatic model_step();
        logic ta, top, sh, kh;
        if (reset) begin
            model_reset();
        end else begin
            ta = tick & enable;
            top = ta && (m_count == m_period_act);
            m_wrap = top;
            if (ta) begin
                for (int c = 0; c < N; c++) begin
                    sh = (m_count == m_start_act[c]);
                    kh = (m_count == m_stop_act[c]);
                    if (m_mode_act[c] == 0) begin
                        m_st[c] = 1'b0;
                        m_pulse[c] = 1'b0;
                    end else if (m_mode_act[c] == 2) begin
                        if (sh) m_st[c] = !m_st[c];
                        m_pulse[c] = m_st[c];
                    end else begin
                        if (sh && kh)  m_st[c] = !m_st[c];
                        else if (sh)   m_st[c] = 1'b1;
                        else if (kh)   m_st[c] = 1'b0;
                        m_pulse[c] = (m_mode_act[c] == 3) ? !m_st[c] : m_st[c];
                    end
                end
            end
            if (top) begin
                for (int c = 0; c < N; c++) begin
                    if (m_mode_sh[c] == 3 && m_mode_act[c] != 3) m_st[c] = 1'b0;
                    m_start_act[c] = m_start_sh[c];
                    m_stop_act[c]  = m_stop_sh[c];
                    m_mode_act[c]  = m_mode_sh[c];
                end
                m_period_act = m_period_sh;
                m_count = 0;
            end else if (ta) begin
                m_count = (m_count + 1) % 256;
            end
            if (wr) begin
                if (wr_sel == 2'd2) m_period_sh = int'(wr_data);
                else if (int'(wr_chan) < N) begin
                    case (wr_sel)
                        2'd0:    m_start_sh[wr_chan] = int'(wr_data);
                        2'd1:    m_stop_sh[wr_chan]  = int'(wr_data);
                        default: m_mode_sh[wr_chan]  = int'(wr_data[1:0]);
                    endcase
                end
            end
        end
        exp_q.push_back('{c: W'(m_count), w: m_wrap, p: m_pulse});
    endtask

    task automatic cyc();
        exp_t e;
        model_step();
        @(posedge sys_clk);
        #1;
        e = exp_q.pop_front();
        check_val("count", 32'(count), 32'(e.c));
        check_val("wrap",  32'(wrap),  32'(e.w));
        check_val("pulse", 32'(pulse), 32'(e.p));
    endtask

    task automatic wr_reg(input int chan, input int sel, input int data);
        wr = 1'b1; wr_chan = CW'(chan); wr_sel = 2'(sel); wr_data = W'(data);
        $display("write chan=%0d sel=%0d data=%0d count=%0d", chan, sel, data, count);
        cyc();
        wr = 1'b0;
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 300 && int'(count) != target; i++) cyc();
        check_val("run_to", 32'(count), 32'(target));
    endtask

    int p0_hi, p2_lo, n_wraps, tog1, diff13, nz;
    logic prev1;

    initial begin
        model_reset();
        cyc();
        cyc();
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_pulse", 32'(pulse), 32'd0);
        reset = 1'b0;
        cyc();

        // Program while frozen; values load at the first wrap.
        wr_reg(0, 2, 99);
        wr_reg(0, 0, 10); wr_reg(0, 1, 20); wr_reg(0, 3, 1);
        wr_reg(1, 0, 5);  wr_reg(1, 1, 5);  wr_reg(1, 3, 1);
        wr_reg(2, 0, 30); wr_reg(2, 1, 60); wr_reg(2, 3, 3);
        wr_reg(3, 0, 5);  wr_reg(3, 3, 2);
        wr_reg(5, 0, 0);  wr_reg(5, 3, 2);  wr_reg(7, 3, 1);
        check_val("frozen_count", 32'(count), 32'd0);

        enable = 1'b1; tick = 1'b1;
        for (int i = 0; i < 300 && wrap !== 1'b1; i++) cyc();
        check_val("first_wrap", 32'(wrap), 32'd1);
        cyc();

        p0_hi = 0; p2_lo = 0; n_wraps = 0; tog1 = 0; diff13 = 0; prev1 = pulse[1];
        for (int i = 0; i < 200; i++) begin
            cyc();
            p0_hi   += int'(pulse[0]);
            p2_lo   += int'(!pulse[2]);
            n_wraps += int'(wrap);
            tog1    += int'(pulse[1] != prev1);
            diff13  += int'(pulse[1] != pulse[3]);
            prev1    = pulse[1];
        end
        check_val("p0_high_cycles", 32'(p0_hi), 32'd20);
        check_val("p2_low_cycles", 32'(p2_lo), 32'd60);
        check_val("wraps_200", 32'(n_wraps), 32'd2);
        check_val("p1_toggles", 32'(tog1), 32'd2);
        check_val("jk_vs_tog", 32'(diff13), 32'd0);
        check_val("chan4_idle", 32'(pulse[4]), 32'd0);

        run_to(30); cyc();
        check_val("jkinv_low_at31", 32'(pulse[2]), 32'd0);

        // Mid-period write, then a write on the wrapping tick.
        run_to(40);
        wr_reg(0, 0, 50);
        run_to(99);
        wr_reg(0, 0, 10);
        run_to(11);
        check_val("start50_no_rise_at10", 32'(pulse[0]), 32'd0);
        run_to(51);
        check_val("start50_rise", 32'(pulse[0]), 32'd1);
        run_to(99); cyc();
        run_to(11);
        check_val("start10_rise", 32'(pulse[0]), 32'd1);
        wr_reg(5, 0, 77); wr_reg(6, 3, 0);

        // Freeze with ticks still arriving.
        run_to(12);
        enable = 1'b0;
        for (int i = 0; i < 20; i++) cyc();
        check_val("hold_count", 32'(count), 32'd12);
        check_val("hold_wrap", 32'(wrap), 32'd0);
        check_val("hold_pulse0", 32'(pulse[0]), 32'd1);
        enable = 1'b1;
        cyc();
        check_val("resume_count", 32'(count), 32'd13);

        // Asynchronous reset mid-pulse.
        run_to(15);
        check_val("pre_reset_p0", 32'(pulse[0]), 32'd1);
        reset = 1'b1;
        #2;
        check_val("async_count", 32'(count), 32'd0);
        check_val("async_pulse", 32'(pulse), 32'd0);
        cyc();
        reset = 1'b0;
        nz = 0;
        wr_reg(0, 2, 9);
        for (int i = 0; i < 260; i++) begin
            cyc();
            nz += int'(pulse != '0);
        end
        check_val("post_reset_no_pulse", 32'(nz), 32'd0);

        // Random ticks, enables and register writes with short periods.
        for (int i = 0; i < 700; i++) begin
            tick    = 1'($urandom_range(0, 1));
            enable  = ($urandom_range(0, 7) != 0);
            wr      = ($urandom_range(0, 5) == 0);
            wr_chan = CW'($urandom_range(0, 7));
            wr_sel  = 2'($urandom_range(0, 3));
            wr_data = W'($urandom_range(0, 12));
            if (wr) $display("write chan=%0d sel=%0d data=%0d count=%0d", wr_chan, wr_sel, wr_data, count);
            cyc();
        end
        wr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
